test_status_unit: RTL and testbench
===================================

Name: test_status_unit

Overview:
- Memory-mapped test/status peripheral on the core's data bus; replaces bench-side cycle counting, timeout and manual result inspection.
- Holds run-control, 64-bit cycle and instret counters, a watchdog, a tohost register and NUM_SIG signature slots, which are checked in hardware against an expected vector.
- Drives done/pass/timeout pins so any bench or FPGA top reads one verdict.

Parameters:
- ADDR_W, 6, word-address width of the register window.
- CNT_W, 64, counter width; must be 33..64, read as LO/HI words.
- NUM_SIG, 8, number of 32-bit signature slots; 1..32.
- EXP_SIG, all-zero, NUM_SIG*32-bit expected signature; slot 0 in bits [31:0].
- TIMEOUT_CYCLES, 3000000, watchdog limit in RUN cycles; 0 disables the watchdog.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- sel  in  1  bus access strobe
- we  in  1  write enable, qualified by sel
- addr  in  ADDR_W  word address
- wdata  in  32  write data
- rdata  out  32  read data, registered
- retire  in  1  one-cycle pulse per retired instruction
- done  out  1  run finished (pass or fail)
- pass  out  1  valid when done=1
- timeout  out  1  watchdog fired
- cycle_count  out  CNT_W  live cycle counter

Behaviour:
- Interface: reset reset, asynchronous, active-low; clock clk.
- Reset: state IDLE; all counters, slots, tohost, rdata, done, pass and timeout = 0; mismatch index = 0.
- Map (word offsets):
  - 0 CTRL (W): bit0 start, bit1 clear.
  - 1 STATUS (R): [0] running, [1] done, [2] pass, [3] timeout, [4] checking, [12:8] mismatch index, [31:16] tohost[15:0].
  - 2 TOHOST (W/R).
  - 3 CYCLE_LO, 4 CYCLE_HI, 5 INSTRET_LO, 6 INSTRET_HI (R).
  - 8..8+NUM_SIG-1 SIG slots (W/R).
  - Unmapped reads return 0; unmapped writes are ignored.
- Writes take effect at the clk edge where sel&we=1. Reads: rdata is valid the cycle after sel&~we and holds until the next read.
- Reading CYCLE_LO snapshots the upper bits into a shadow; the next CYCLE_HI read returns the shadow. INSTRET_LO/HI behave the same.
- FSM states:
  - IDLE: CTRL.start -> RUN. Counters are held.
  - RUN: cycle counter +1 per clk; instret +1 per retire pulse; both wrap at 2^CNT_W.
    - TOHOST write of 1 -> CHECK.
    - TOHOST write of any other nonzero value -> DONE with pass=0.
    - TOHOST write of 0 is stored; no state change.
    - Cycle counter == TIMEOUT_CYCLES-1 with TIMEOUT_CYCLES != 0 -> TIMEOUT.
  - CHECK: compares one slot per cycle, index 0..NUM_SIG-1; counters frozen.
    - First mismatch -> DONE with pass=0; mismatch index = that slot.
    - All slots match -> DONE with pass=1. Latency is exactly NUM_SIG cycles after the TOHOST write edge.
  - DONE: done=1. TIMEOUT: done=1, timeout=1, pass=0.
- CTRL.clear from any state -> IDLE; zeroes counters, tohost, flags and mismatch index. Signature slots are kept.
- If clear and start are written together, clear wins and the next state is IDLE.
- TOHOST write on the same edge the watchdog expires: the TOHOST write wins.
- CTRL.start outside IDLE is ignored.
- SIG and TOHOST writes in CHECK, DONE or TIMEOUT are ignored.
- Async reset mid-CHECK aborts the check and returns the unit to the reset state immediately.

Optional Feature:
- TSU_INSTRET_EN defined: instret counter and its shadow are present; retire is counted.
- TSU_INSTRET_EN undefined: offsets 5/6 read 0; retire is ignored; no instret flops are synthesised.

Decomposition:
- Package tsu_pkg holds:
  - register offset localparams;
  - FSM state enum (IDLE, RUN, CHECK, DONE, TIMEOUT);
  - CTRL and STATUS bit-position constants.
- Sub-module tsu_counter: CNT_W-bit enable/clear counter with LO-read snapshot shadow. Instantiated for cycles, and for instret under TSU_INSTRET_EN.

Test Plan:
- Start with TIMEOUT_CYCLES=0, 100 idle cycles, read CYCLE_LO then CYCLE_HI -> LO=100±1 cycle of bus latency, HI=0; STATUS running=1.
- EXP_SIG = SHA-256("hello world") = b94d27b9 934d3e08 a52e52d7 da7dabfa c484efe3 7a5380ee 9088f7ac e2efcde9; write the 8 matching slots, then TOHOST=1 -> done=1, pass=1 exactly 8 cycles later.
- Same setup but slot 5 = 0x7a5380ef -> pass=0; STATUS mismatch index=5; done asserted 6 cycles after the TOHOST write.
- TIMEOUT_CYCLES=50, start, no TOHOST -> timeout=1, done=1, pass=0 at RUN cycle 50; a later TOHOST=1 write is ignored.
- TOHOST=1 written on the watchdog-expiry edge -> CHECK entered, timeout stays 0. Then CTRL=0x3 -> IDLE with counters 0 and slots retained.
- Pulse reset low mid-CHECK -> all outputs 0 asynchronously. Under TSU_INSTRET_EN, 37 retire pulses in RUN -> INSTRET_LO=37; without it -> 0.

Source files
------------

// File: rtl/tsu_pkg.sv
// Shared definitions for the test/status unit: register map,
// FSM states and CTRL/STATUS bit positions.
package tsu_pkg;

    localparam logic [31:0] OFF_CTRL    = 32'd0;
    localparam logic [31:0] OFF_STATUS  = 32'd1;
    localparam logic [31:0] OFF_TOHOST  = 32'd2;
    localparam logic [31:0] OFF_CYC_LO  = 32'd3;
    localparam logic [31:0] OFF_CYC_HI  = 32'd4;
    localparam logic [31:0] OFF_INS_LO  = 32'd5;
    localparam logic [31:0] OFF_INS_HI  = 32'd6;
    localparam logic [31:0] OFF_SIG     = 32'd8;

    localparam int CTRL_START = 0;
    localparam int CTRL_CLEAR = 1;

    localparam int STAT_RUNNING = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_PASS    = 2;
    localparam int STAT_TIMEOUT = 3;
    localparam int STAT_CHECK   = 4;
    localparam int STAT_MIS_LSB = 8;
    localparam int STAT_TH_LSB  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_CHECK,
        ST_DONE,
        ST_TIMEOUT
    } tsu_state_e;

endpackage

// File: rtl/tsu_counter.sv
// Enable/clear counter; a LO-word read snapshots the upper bits
// into a shadow so a following HI read is coherent.
module tsu_counter #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic             snap,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-33:0] shadow
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= '0;
            shadow <= '0;
        end else if (clr) begin
            count  <= '0;
            shadow <= '0;
        end else begin
            if (en)
                count <= count + CNT_W'(1);
            if (snap)
                shadow <= count[CNT_W-1:32];
        end
    end

endmodule

// File: rtl/test_status_unit.sv
// Memory-mapped test/status peripheral with hardware signature check.
// Define TSU_INSTRET_EN to include the retired-instruction counter.
module test_status_unit
    import tsu_pkg::*;
#(
    parameter int                     ADDR_W         = 6,
    parameter int                     CNT_W          = 64,
    parameter int                     NUM_SIG        = 8,
    parameter logic [NUM_SIG*32-1:0]  EXP_SIG        = '0,
    parameter longint unsigned        TIMEOUT_CYCLES = 3000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sel,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    input  logic              retire,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycle_count
);

    localparam bit              WD_EN  = TIMEOUT_CYCLES != 0;
    localparam logic [CNT_W-1:0] WD_LIM =
        WD_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [4:0]      LAST   = 5'(NUM_SIG - 1);

    tsu_state_e        state;
    logic [31:0]       sig [NUM_SIG];
    logic [31:0]       tohost;
    logic [4:0]        chk_idx;
    logic [4:0]        mis_idx;
    logic [31:0]       a;
    logic              wr, rd, open, running;
    logic              clr, start, th_wr;
    logic              wd_hit;
    logic [31:0]       cur_sig, cur_exp;
    logic [31:0]       status, rd_val;
    logic [CNT_W-33:0] cyc_sh;

    assign a       = 32'(addr);
    assign wr      = sel & we;
    assign rd      = sel & ~we;
    assign running = state == ST_RUN;
    assign open    = (state == ST_IDLE) || running;
    assign clr     = wr && a == OFF_CTRL && wdata[CTRL_CLEAR];
    assign start   = wr && a == OFF_CTRL && wdata[CTRL_START];
    assign th_wr   = wr && a == OFF_TOHOST && open;
    assign wd_hit  = WD_EN && cycle_count == WD_LIM;

    tsu_counter #(.CNT_W(CNT_W)) u_cyc (
        .clk    (clk),
        .reset  (reset),
        .en     (running),
        .clr    (clr),
        .snap   (rd && a == OFF_CYC_LO),
        .count  (cycle_count),
        .shadow (cyc_sh)
    );

`ifdef TSU_INSTRET_EN
    logic [CNT_W-1:0]  ins;
    logic [CNT_W-33:0] ins_sh;

    tsu_counter #(.CNT_W(CNT_W)) u_ins (
        .clk    (clk),
        .reset  (reset),
        .en     (running & retire),
        .clr    (clr),
        .snap   (rd && a == OFF_INS_LO),
        .count  (ins),
        .shadow (ins_sh)
    );
`else
    logic unused_retire;
    assign unused_retire = retire;
`endif

    always_comb begin
        cur_sig = '0;
        cur_exp = '0;
        for (int i = 0; i < NUM_SIG; i++) begin
            if (chk_idx == 5'(i)) begin
                cur_sig = sig[i];
                cur_exp = EXP_SIG[32*i +: 32];
            end
        end
    end

    always_comb begin
        status = '0;
        status[STAT_RUNNING] = running;
        status[STAT_DONE]    = done;
        status[STAT_PASS]    = pass;
        status[STAT_TIMEOUT] = timeout;
        status[STAT_CHECK]   = state == ST_CHECK;
        status[STAT_MIS_LSB +: 5] = mis_idx;
        status[STAT_TH_LSB +: 16] = tohost[15:0];
    end

    always_comb begin
        rd_val = '0;
        unique case (1'b1)
            a == OFF_STATUS: rd_val = status;
            a == OFF_TOHOST: rd_val = tohost;
            a == OFF_CYC_LO: rd_val = cycle_count[31:0];
            a == OFF_CYC_HI: rd_val = 32'(cyc_sh);
`ifdef TSU_INSTRET_EN
            a == OFF_INS_LO: rd_val = ins[31:0];
            a == OFF_INS_HI: rd_val = 32'(ins_sh);
`endif
            default: begin
                for (int i = 0; i < NUM_SIG; i++)
                    if (a == OFF_SIG + 32'(i))
                        rd_val = sig[i];
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rdata <= '0;
        else if (rd)
            rdata <= rd_val;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SIG; i++)
                sig[i] <= '0;
        end else if (wr && open) begin
            for (int i = 0; i < NUM_SIG; i++)
                if (a == OFF_SIG + 32'(i))
                    sig[i] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            tohost  <= '0;
            chk_idx <= '0;
            mis_idx <= '0;
            done    <= 1'b0;
            pass    <= 1'b0;
            timeout <= 1'b0;
        end else if (clr) begin
            state   <= ST_IDLE;
            tohost  <= '0;
            chk_idx <= '0;
            mis_idx <= '0;
            done    <= 1'b0;
            pass    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            if (th_wr)
                tohost <= wdata;
            unique case (state)
                ST_IDLE: if (start) state <= ST_RUN;
                ST_RUN: begin
                    // A tohost write beats a same-edge watchdog expiry
                    if (th_wr && wdata == 32'd1) begin
                        state   <= ST_CHECK;
                        chk_idx <= '0;
                    end else if (th_wr && wdata != 32'd0) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else if (wd_hit) begin
                        state   <= ST_TIMEOUT;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (cur_sig != cur_exp) begin
                        state   <= ST_DONE;
                        done    <= 1'b1;
                        mis_idx <= chk_idx;
                    end else if (chk_idx == LAST) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        pass  <= 1'b1;
                    end else begin
                        chk_idx <= chk_idx + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_test_status_unit.sv
// Self-checking bench for test_status_unit: two instances, one with
// the watchdog disabled and one with a 50-cycle watchdog.
module tb_test_status_unit;

    localparam logic [255:0] SHA = {
        32'he2efcde9, 32'h9088f7ac, 32'h7a5380ee, 32'hc484efe3,
        32'hda7dabfa, 32'ha52e52d7, 32'h934d3e08, 32'hb94d27b9
    };

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sel = 1'b0;
    logic        we = 1'b0;
    logic [5:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic        retire = 1'b0;
    logic        tgt = 1'b0;
    logic        sel0, sel1;
    logic [31:0] rdata0, rdata1;
    logic        done0, pass0, timeout0;
    logic        done1, pass1, timeout1;
    logic [63:0] cc0, cc1;

    logic [31:0] exp_q [$];
    logic [255:0] sha_v;
    int n_chk = 0;
    int n_err = 0;

    assign sel0 = sel & ~tgt;
    assign sel1 = sel & tgt;

    always #5 clk = ~clk;

    test_status_unit #(
        .EXP_SIG(SHA), .TIMEOUT_CYCLES(0)
    ) u0 (
        .clk(clk), .reset(reset), .sel(sel0), .we(we),
        .addr(addr), .wdata(wdata), .rdata(rdata0),
        .retire(retire), .done(done0), .pass(pass0),
        .timeout(timeout0), .cycle_count(cc0)
    );

    test_status_unit #(
        .EXP_SIG(SHA), .TIMEOUT_CYCLES(50)
    ) u1 (
        .clk(clk), .reset(reset), .sel(sel1), .we(we),
        .addr(addr), .wdata(wdata), .rdata(rdata1),
        .retire(1'b0), .done(done1), .pass(pass1),
        .timeout(timeout1), .cycle_count(cc1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        tick();
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a, output logic [31:0] d);
        sel = 1'b1; we = 1'b0; addr = a;
        tick();
        sel = 1'b0;
        d = tgt ? rdata1 : rdata0;
    endtask

    task automatic test_reset();
        #12;
        n_chk++;
        if ({done0, pass0, timeout0, done1, pass1, timeout1} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 000000",
                {done0, pass0, timeout0, done1, pass1, timeout1});
        end
        n_chk++;
        if (cc0 !== 64'd0 || cc1 !== 64'd0) begin
            n_err++;
            $display("FAIL reset_cycles: got %0d/%0d want 0", cc0, cc1);
        end
        n_chk++;
        if (rdata0 !== 32'd0 || rdata1 !== 32'd0) begin
            n_err++;
            $display("FAIL reset_rdata: got %h/%h want 0", rdata0, rdata1);
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_counters();
        logic [5:0]  ra [5] = '{6'd3, 6'd4, 6'd1, 6'd7, 6'd16};
        logic [31:0] d, e;
        tgt = 1'b0;
        wr(6'd0, 32'd1);
        repeat (100) tick();
        exp_q.push_back(32'd100);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        foreach (ra[i]) begin
            rd(ra[i], d);
            e = exp_q.pop_front();
            n_chk++;
            if (d !== e) begin
                n_err++;
                $display("FAIL counters_rd%0d: got %h want %h", ra[i], d, e);
            end
        end
        n_chk++;
        if (cc0 !== 64'd105) begin
            n_err++;
            $display("FAIL counters_pin: got %0d want 105", cc0);
        end
    endtask

    task automatic test_pass();
        logic [31:0] d, e;
        tgt = 1'b0;
        wr(6'd0, 32'd2);
        for (int i = 0; i < 8; i++)
            wr(6'(8 + i), sha_v[32*i +: 32]);
        wr(6'd0, 32'd1);
        wr(6'd2, 32'd1);
        for (int i = 1; i <= 8; i++) begin
            tick();
            n_chk++;
            if (done0 !== (i == 8)) begin
                n_err++;
                $display("FAIL pass_latency@%0d: got %b want %b",
                    i, done0, i == 8);
            end
        end
        n_chk++;
        if (pass0 !== 1'b1) begin
            n_err++;
            $display("FAIL pass_pin: got %b want 1", pass0);
        end
        exp_q.push_back(32'h0001_0006);
        rd(6'd1, d);
        e = exp_q.pop_front();
        n_chk++;
        if (d !== e) begin
            n_err++;
            $display("FAIL pass_status: got %h want %h", d, e);
        end
    endtask

    task automatic test_mismatch();
        logic [31:0] d, e;
        tgt = 1'b0;
        wr(6'd0, 32'd2);
        wr(6'd13, 32'h7a5380ef);
        wr(6'd0, 32'd1);
        wr(6'd2, 32'd1);
        for (int i = 1; i <= 8; i++) begin
            tick();
            n_chk++;
            if (done0 !== (i >= 6)) begin
                n_err++;
                $display("FAIL mis_latency@%0d: got %b want %b",
                    i, done0, i >= 6);
            end
        end
        n_chk++;
        if (pass0 !== 1'b0) begin
            n_err++;
            $display("FAIL mis_pass: got %b want 0", pass0);
        end
        wr(6'd8, 32'd0);
        exp_q.push_back(32'h0001_0502);
        exp_q.push_back(32'hb94d27b9);
        rd(6'd1, d);
        e = exp_q.pop_front();
        n_chk++;
        if (d !== e) begin
            n_err++;
            $display("FAIL mis_status: got %h want %h", d, e);
        end
        rd(6'd8, d);
        e = exp_q.pop_front();
        n_chk++;
        if (d !== e) begin
            n_err++;
            $display("FAIL mis_sig_locked: got %h want %h", d, e);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] d, e;
        tgt = 1'b1;
        wr(6'd0, 32'd1);
        for (int i = 1; i <= 50; i++) begin
            tick();
            if (i == 49) begin
                n_chk++;
                if (timeout1 !== 1'b0) begin
                    n_err++;
                    $display("FAIL wd_early: got %b want 0", timeout1);
                end
            end
        end
        n_chk++;
        if ({timeout1, done1, pass1} !== 3'b110) begin
            n_err++;
            $display("FAIL wd_fire: got %b want 110",
                {timeout1, done1, pass1});
        end
        wr(6'd2, 32'd1);
        exp_q.push_back(32'h0000_000a);
        exp_q.push_back(32'd0);
        rd(6'd1, d);
        e = exp_q.pop_front();
        n_chk++;
        if (d !== e) begin
            n_err++;
            $display("FAIL wd_status: got %h want %h", d, e);
        end
        rd(6'd2, d);
        e = exp_q.pop_front();
        n_chk++;
        if (d !== e) begin
            n_err++;
            $display("FAIL wd_tohost: got %h want %h", d, e);
        end
        n_chk++;
        if (cc1 !== 64'd50) begin
            n_err++;
            $display("FAIL wd_frozen: got %0d want 50", cc1);
        end
    endtask

    task automatic test_expiry_race();
        logic [5:0]  ra [3] = '{6'd13, 6'd8, 6'd3};
        logic [31:0] d, e;
        tgt = 1'b1;
        wr(6'd0, 32'd2);
        wr(6'd0, 32'd1);
        repeat (49) tick();
        wr(6'd2, 32'd1);
        n_chk++;
        if ({timeout1, done1} !== 2'b00) begin
            n_err++;
            $display("FAIL race_edge: got %b want 00", {timeout1, done1});
        end
        exp_q.push_back(32'h0001_0010);
        rd(6'd1, d);
        e = exp_q.pop_front();
        n_chk++;
        if (d !== e) begin
            n_err++;
            $display("FAIL race_status: got %h want %h", d, e);
        end
        n_chk++;
        if ({timeout1, done1, pass1} !== 3'b010) begin
            n_err++;
            $display("FAIL race_verdict: got %b want 010",
                {timeout1, done1, pass1});
        end
        wr(6'd0, 32'd3);
        exp_q.push_back(32'd0);
        rd(6'd1, d);
        e = exp_q.pop_front();
        n_chk++;
        if (d !== e || cc1 !== 64'd0) begin
            n_err++;
            $display("FAIL race_clear: got %h/%0d want 0/0", d, cc1);
        end
        tgt = 1'b0;
        wr(6'd0, 32'd3);
        exp_q.push_back(32'h7a5380ef);
        exp_q.push_back(32'hb94d27b9);
        exp_q.push_back(32'd0);
        foreach (ra[i]) begin
            rd(ra[i], d);
            e = exp_q.pop_front();
            n_chk++;
            if (d !== e) begin
                n_err++;
                $display("FAIL clear_keep%0d: got %h want %h", ra[i], d, e);
            end
        end
    endtask

    task automatic test_instret();
        logic [31:0] d, e;
        tgt = 1'b0;
        repeat (3) begin
            retire = 1'b1; tick(); retire = 1'b0; tick();
        end
        wr(6'd0, 32'd1);
        repeat (37) begin
            retire = 1'b1; tick(); retire = 1'b0; tick();
        end
`ifdef TSU_INSTRET_EN
        exp_q.push_back(32'd37);
`else
        exp_q.push_back(32'd0);
`endif
        exp_q.push_back(32'd0);
        rd(6'd5, d);
        e = exp_q.pop_front();
        n_chk++;
        if (d !== e) begin
            n_err++;
            $display("FAIL instret_lo: got %0d want %0d", d, e);
        end
        rd(6'd6, d);
        e = exp_q.pop_front();
        n_chk++;
        if (d !== e) begin
            n_err++;
            $display("FAIL instret_hi: got %0d want %0d", d, e);
        end
    endtask

    task automatic test_reset_mid_check();
        logic [31:0] d, e;
        tgt = 1'b0;
        rd(6'd8, d);
        wr(6'd2, 32'd1);
        tick();
        tick();
        #2 reset = 1'b0;
        #1;
        n_chk++;
        if ({done0, pass0, timeout0} !== 3'b0 || cc0 !== 64'd0 ||
            rdata0 !== 32'd0) begin
            n_err++;
            $display("FAIL async_reset: got %b/%0d/%h want 000/0/0",
                {done0, pass0, timeout0}, cc0, rdata0);
        end
        #1 reset = 1'b1;
        repeat (8) tick();
        n_chk++;
        if (done0 !== 1'b0) begin
            n_err++;
            $display("FAIL check_aborted: got %b want 0", done0);
        end
        exp_q.push_back(32'd0);
        rd(6'd1, d);
        e = exp_q.pop_front();
        n_chk++;
        if (d !== e) begin
            n_err++;
            $display("FAIL post_reset_status: got %h want %h", d, e);
        end
    endtask

    initial begin
        sha_v = SHA;
        test_reset();
        test_counters();
        test_pass();
        test_mismatch();
        test_timeout();
        test_expiry_race();
        test_instret();
        test_reset_mid_check();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
